// File: rtl/regfile_pkg.sv
// Shared sizing and types for the integer register file.
// Defaults target RV32I; RV32E builds override NREGS to 16.
package regfile_pkg;
  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;
  localparam int AW       = $clog2(RF_NREGS);

  typedef logic [AW-1:0]      reg_addr_t;
  typedef logic [RF_XLEN-1:0] xlen_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-load scoreboard: one bit per register, set on load issue,
// cleared by load return or flush, looked up for every read port.
import regfile_pkg::*;

module rf_scoreboard #(
  parameter  int NREGS  = RF_NREGS,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_addr,
  input  logic              wb0_en,
  input  logic [AW-1:0]     wb0_addr,
  input  logic              flush,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy
);

  logic [NREGS-1:0] r_pend;
  logic [NREGS-1:0] w_pend_nxt;

  // Flush beats alloc, alloc beats a same-cycle load return.
  always_comb begin
    w_pend_nxt = r_pend;
    for (int r = 1; r < NREGS; r++) begin
      if (flush)
        w_pend_nxt[r] = 1'b0;
      else if (alloc_en && alloc_addr == AW'(r))
        w_pend_nxt[r] = 1'b1;
      else if (wb0_en && wb0_addr == AW'(r))
        w_pend_nxt[r] = 1'b0;
    end
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_pend <= '0;
    else
      r_pend <= w_pend_nxt;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_busy
    logic [AW-1:0] w_a;
    logic          w_rel;
    assign w_a   = rd_addr[i*AW +: AW];
    assign w_rel = (BYPASS != 0) && wb0_en
                   && (wb0_addr == w_a) && !flush;
    assign rd_busy[i] = (w_a != '0) && r_pend[w_a] && !w_rel;
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file: NRD combinational reads, two
// writeback ports (WB1 wins on collision), bypass and load scoreboard.
import regfile_pkg::*;

module register_file_mp #(
  parameter  int XLEN   = RF_XLEN,
  parameter  int NREGS  = RF_NREGS,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wb0_en,
  input  logic [AW-1:0]       wb0_addr,
  input  logic [XLEN-1:0]     wb0_data,
  input  logic                wb1_en,
  input  logic [AW-1:0]       wb1_addr,
  input  logic [XLEN-1:0]     wb1_data,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  input  logic                flush
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_wb0_we;
  logic            w_wb1_we;

  // The ALU result is younger than the load, so WB1 takes a shared slot.
  assign w_wb1_we = wb1_en && (wb1_addr != '0);
  assign w_wb0_we = wb0_en && (wb0_addr != '0)
                    && !(w_wb1_we && wb1_addr == wb0_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++)
        r_regs[r] <= '0;
    end else begin
      if (w_wb0_we)
        r_regs[wb0_addr] <= wb0_data;
      if (w_wb1_we)
        r_regs[wb1_addr] <= wb1_data;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   w_a;
    logic [XLEN-1:0] w_d;
    assign w_a = rd_addr[i*AW +: AW];
    always_comb begin
      w_d = r_regs[w_a];
      if (BYPASS != 0) begin
        if (wb0_en && wb0_addr == w_a)
          w_d = wb0_data;
        if (wb1_en && wb1_addr == w_a)
          w_d = wb1_data;
      end
      if (w_a == '0)
        w_d = '0;
    end
    assign rd_data[i*XLEN +: XLEN] = w_d;
  end

  rf_scoreboard #(
    .NREGS  (NREGS),
    .NRD    (NRD),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .wb0_en     (wb0_en),
    .wb0_addr   (wb0_addr),
    .flush      (flush),
    .rd_addr    (rd_addr),
    .rd_busy    (rd_busy)
  );

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: directed cases with literal expectations,
// then random traffic compared every cycle against a behavioural model.
import regfile_pkg::*;

module tb_register_file_mp;
  localparam int XLEN = 32;
  localparam int NR   = 32;
  localparam int NRD  = 2;
  localparam int AWL  = 5;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [NRD*AWL-1:0]  rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wb0_en = 1'b0;
  reg_addr_t           wb0_addr = '0;
  xlen_t               wb0_data = '0;
  logic                wb1_en = 1'b0;
  reg_addr_t           wb1_addr = '0;
  xlen_t               wb1_data = '0;
  logic                alloc_en = 1'b0;
  reg_addr_t           alloc_addr = '0;
  logic                flush = 1'b0;

  int total = 0;
  int bad = 0;
  bit cmp_on = 1'b0;

  // Behavioural model state
  xlen_t mem [NR];
  bit    pend [NR];

  register_file_mp #(
    .XLEN(XLEN), .NREGS(NR), .NRD(NRD), .BYPASS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NR; r++) begin
        mem[r] = '0;
        pend[r] = 1'b0;
      end
    end else begin
      if (wb0_en && wb0_addr != 0) mem[wb0_addr] = wb0_data;
      if (wb1_en && wb1_addr != 0) mem[wb1_addr] = wb1_data;
      if (wb0_en) pend[wb0_addr] = 1'b0;
      if (alloc_en) pend[alloc_addr] = 1'b1;
      if (flush)
        for (int r = 0; r < NR; r++) pend[r] = 1'b0;
      pend[0] = 1'b0;
    end
  end

  function automatic xlen_t exp_data(input int a);
    if (a == 0) return '0;
    if (wb1_en && wb1_addr == a) return wb1_data;
    if (wb0_en && wb0_addr == a) return wb0_data;
    return mem[a];
  endfunction

  function automatic bit exp_busy(input int a);
    if (a == 0) return 1'b0;
    if (wb0_en && wb0_addr == a && !flush) return 1'b0;
    return pend[a];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int port_a(input int p);
    return int'(rd_addr[p*AWL +: AWL]);
  endfunction

  // Per-cycle model comparison on the falling edge
  always @(negedge clk) begin
    if (rst_n && cmp_on) begin
      for (int p = 0; p < NRD; p++) begin
        chk("model_data", rd_data[p*XLEN +: XLEN], exp_data(port_a(p)));
        chk("model_busy", 32'(rd_busy[p]), 32'(exp_busy(port_a(p))));
      end
    end
  end

  task automatic idle();
    wb0_en = 0; wb1_en = 0; alloc_en = 0; flush = 0;
  endtask

  task automatic rd2(input int a, input int b);
    rd_addr = {AWL'(b), AWL'(a)};
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data", rd_data[31:0], 32'h0);
    rst_n = 1'b1;
    cmp_on = 1'b1;

    for (int a = 1; a < NR; a++) begin
      rd2(a, NR - a);
      #1;
      chk("rst_rd0", rd_data[31:0], 32'h0);
      chk("rst_rd1", rd_data[63:32], 32'h0);
      chk("rst_busy", 32'(rd_busy), 32'h0);
    end

    idle(); wb1_en = 1; wb1_addr = 5; wb1_data = 32'hDEADBEEF;
    rd2(5, 5);
    #1 chk("byp_x5", rd_data[31:0], 32'hDEADBEEF);
    next(); idle();
    #1 chk("arr_x5", rd_data[63:32], 32'hDEADBEEF);

    next();
    wb0_en = 1; wb0_addr = 7; wb0_data = 32'h11;
    wb1_en = 1; wb1_addr = 7; wb1_data = 32'h22;
    rd2(7, 0);
    #1 chk("coll_byp_x7", rd_data[31:0], 32'h22);
    next(); idle();
    wb1_en = 1; wb1_addr = 0; wb1_data = 32'hFF;
    #1 chk("coll_arr_x7", rd_data[31:0], 32'h22);
    chk("x0_byp", rd_data[63:32], 32'h0);
    next(); idle();
    #1 chk("x0_arr", rd_data[63:32], 32'h0);

    next();
    alloc_en = 1; alloc_addr = 9; rd2(9, 9);
    next(); idle();
    #1 chk("x9_busy", 32'(rd_busy), 32'h3);
    next();
    wb0_en = 1; wb0_addr = 9; wb0_data = 32'h33;
    #1 chk("x9_rel", 32'(rd_busy), 32'h0);
    chk("x9_data", rd_data[31:0], 32'h33);
    next(); idle();
    #1 chk("x9_clr", 32'(rd_busy), 32'h0);

    next();
    alloc_en = 1; alloc_addr = 3; wb0_en = 1; wb0_addr = 3;
    wb0_data = 32'h44; rd2(3, 4);
    next(); idle();
    #1 chk("x3_pend", 32'(rd_busy), 32'h1);
    flush = 1; alloc_en = 1; alloc_addr = 4;
    next(); idle();
    #1 chk("flush_busy", 32'(rd_busy), 32'h0);

    next();
    wb1_en = 1; wb1_addr = 10; wb1_data = 32'h1234;
    rd2(10, 10);
    next(); idle();
    #1 chk("x10_wr", rd_data[31:0], 32'h1234);
    #1 rst_n = 1'b0;
    #1 chk("x10_async", rd_data[31:0], 32'h0);
    next();
    rst_n = 1'b1;

    for (int c = 0; c < 600; c++) begin
      next();
      wb0_en     = ($urandom_range(0, 2) == 0);
      wb1_en     = ($urandom_range(0, 2) == 0);
      alloc_en   = ($urandom_range(0, 2) == 0);
      flush      = ($urandom_range(0, 15) == 0);
      wb0_addr   = reg_addr_t'($urandom_range(0, 7));
      wb1_addr   = reg_addr_t'($urandom_range(0, 7));
      alloc_addr = reg_addr_t'($urandom_range(0, 7));
      wb0_data   = $urandom;
      wb1_data   = $urandom;
      if (c % 4 == 0) rd2($urandom_range(0, 31), $urandom_range(0, 31));
      else rd2($urandom_range(0, 7), $urandom_range(0, 7));
    end
    next(); idle();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
